// File: rtl/bf_envelope_detect_pkg.sv
// bf_envelope_detect_pkg: shared widths, envelope tuning constants and FSM state encodings
package bf_envelope_detect_pkg;
  localparam int IN_W = 18;
  localparam int OUT_W = 8;
  localparam int AVG_LOG2 = 3;
  localparam int DEC = 4;
  localparam int SHIFT = 4;
  localparam int LINE_LEN = 256;
  localparam int FIFO_D = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
endpackage

// File: rtl/bf_envelope_detect_if.sv
// bf_envelope_detect_if: beamformed sample input (bf_data/bf_valid) and pixel valid/ready output (pix_data/pix_valid/pix_ready/pix_last)
interface bf_envelope_detect_if;
  import bf_envelope_detect_pkg::*;
  logic signed [IN_W-1:0] bf_data;
  logic bf_valid;
  logic [OUT_W-1:0] pix_data;
  logic pix_valid;
  logic pix_ready;
  logic pix_last;
  modport master (output bf_data, bf_valid, pix_ready, input pix_data, pix_valid, pix_last);
  modport slave (input bf_data, bf_valid, pix_ready, output pix_data, pix_valid, pix_last);
endinterface

// File: rtl/bf_envelope_detect_sync_fifo.sv
// bf_envelope_detect_sync_fifo: pixel+last storage with full/empty flags, same-cycle push/pop; ports clk, reset, push, din, pop, dout (0 when empty), full, empty
module bf_envelope_detect_sync_fifo #(
  parameter int W = 9,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic wen, ren;
  always_comb begin
    empty = cnt == '0;
    full = cnt == (AW+1)'(D);
    ren = pop && !empty;
    wen = push && (!full || ren);
    dout = empty ? '0 : mem[rd];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      wr <= wr + AW'(wen);
      rd <= rd + AW'(ren);
      cnt <= cnt + (AW+1)'(wen) - (AW+1)'(ren);
    end
  end
  always_ff @(posedge clk)
    if (wen) mem[wr] <= din;
endmodule

// File: rtl/bf_envelope_detect.sv
// bf_envelope_detect: rectify -> boxcar -> decimate -> gain shift -> saturate -> pixel FIFO for one scanline; ports clk, reset, line_start, bus (bf in / pix out), busy, overflow, debug_state
module bf_envelope_detect
  import bf_envelope_detect_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   line_start,
  bf_envelope_detect_if.slave    bus,
  output logic                   busy,
  output logic                   overflow,
  output logic [1:0]             debug_state
);
  localparam int WIN = 1 << AVG_LOG2;
  localparam int SW = IN_W - 1 + AVG_LOG2;
  localparam int DW = $clog2(DEC);
  localparam int PW = $clog2(LINE_LEN);
  logic [1:0] state;
  logic [IN_W-1:0] neg;
  logic [IN_W-2:0] abs_c, abs_r;
  logic [IN_W-2:0] win [WIN];
  logic [SW-1:0] sum, avg;
  logic [DW-1:0] dec_cnt;
  logic [PW-1:0] pix_cnt;
  logic [OUT_W-1:0] pix;
  logic [OUT_W:0] head;
  logic acc, start, v1, d1, v2, pop, full, empty, drop, last_pix;
  always_comb begin
    acc = bus.bf_valid && state == S_RUN;
    start = line_start && state == S_IDLE;
    neg = -bus.bf_data;
    abs_c = bus.bf_data[IN_W-1] ? (neg[IN_W-1] ? '1 : neg[IN_W-2:0]) : bus.bf_data[IN_W-2:0];
    avg = sum >> (AVG_LOG2 + SHIFT);
    pix = |avg[SW-1:OUT_W] ? '1 : avg[OUT_W-1:0];
    pop = !empty && bus.pix_ready;
    drop = v2 && full && !pop;
    last_pix = pix_cnt == PW'(LINE_LEN - 1);
  end
  always_ff @(posedge clk) begin
    if (reset || start) begin
      state <= reset ? S_IDLE : S_RUN;
      sum <= '0;
      dec_cnt <= '0;
      pix_cnt <= '0;
      abs_r <= '0;
      v1 <= 1'b0;
      d1 <= 1'b0;
      v2 <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < WIN; i++) win[i] <= '0;
    end else begin
      state <= (state == S_RUN && v2 && last_pix) ? S_DRAIN :
               (state == S_DRAIN && empty) ? S_IDLE : state;
      abs_r <= abs_c;
      v1 <= acc;
      d1 <= acc && dec_cnt == DW'(DEC - 1);
      v2 <= v1 && d1;
      if (acc) dec_cnt <= dec_cnt == DW'(DEC - 1) ? '0 : dec_cnt + DW'(1);
      if (v1) begin
        sum <= sum + SW'(abs_r) - SW'(win[WIN-1]);
        win[0] <= abs_r;
        for (int i = 1; i < WIN; i++) win[i] <= win[i-1];
      end
      if (v2) pix_cnt <= pix_cnt + PW'(1);
      overflow <= overflow | drop;
    end
  end
  bf_envelope_detect_sync_fifo #(.W(OUT_W + 1), .D(FIFO_D)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(v2),
    .din({last_pix, pix}),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign bus.pix_data = head[OUT_W-1:0];
  assign bus.pix_last = head[OUT_W];
  assign bus.pix_valid = !empty;
  assign busy = state != S_IDLE;
  assign debug_state = state;
endmodule

// File: tb/tb_bf_envelope_detect.sv
// tb_bf_envelope_detect: directed and random stimulus checked each cycle against a queue-based scanline model
module tb_bf_envelope_detect;
  import bf_envelope_detect_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic line_start = 1'b0;
  logic busy, overflow;
  logic [1:0] debug_state;
  bf_envelope_detect_if bus();
  bf_envelope_detect dut (
    .clk(clk),
    .reset(reset),
    .line_start(line_start),
    .bus(bus.slave),
    .busy(busy),
    .overflow(overflow),
    .debug_state(debug_state)
  );
  always #5 clk = ~clk;
  typedef struct {int t; int v; bit last;} pend_t;
  typedef struct {int v; bit last;} pix_t;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ms = 0;
  bit ovf = 0;
  int npix = 0;
  int smp[$];
  pend_t pend[$];
  pix_t mq[$];
  int got[$];
  int got_last = 0;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, act, exp);
    end
  endtask
  task automatic model(input bit v, input int d, input bit rdy, input bit ls, input bit rs);
    int pre, n, s, x;
    bit pre_empty;
    pend_t p;
    pre = ms;
    pre_empty = mq.size() == 0;
    if (rs) begin
      ms = 0;
      ovf = 0;
      npix = 0;
      smp.delete();
      pend.delete();
      mq.delete();
    end else begin
      if (!pre_empty && rdy) void'(mq.pop_front());
      if (pend.size() > 0 && pend[0].t == cyc) begin
        p = pend.pop_front();
        if (mq.size() < FIFO_D) mq.push_back('{p.v, p.last});
        else ovf = 1;
        npix++;
        if (npix == LINE_LEN) ms = 2;
      end
      if (pre == 1 && v) begin
        x = $signed(d[17:0]);
        smp.push_back(x < 0 ? (x == -131072 ? 131071 : -x) : x);
        n = smp.size();
        if (n % DEC == 0) begin
          s = 0;
          for (int i = 0; i < 8; i++) if (n - 1 - i >= 0) s += smp[n-1-i];
          pend.push_back('{cyc + 2, (s / 128 > 255) ? 255 : s / 128, n == DEC * LINE_LEN});
        end
      end
      if (pre == 0 && ls) begin
        ms = 1;
        ovf = 0;
        npix = 0;
        smp.delete();
        pend.delete();
      end
      if (pre == 2 && pre_empty) ms = 0;
    end
  endtask
  task automatic step(input bit v, input int d, input bit rdy, input bit ls, input bit rs);
    pix_t h;
    bus.bf_valid = v;
    bus.bf_data = d[17:0];
    bus.pix_ready = rdy;
    line_start = ls;
    reset = rs;
    if (bus.pix_valid && rdy && !rs) begin
      got.push_back(int'(bus.pix_data));
      got_last += int'(bus.pix_last);
    end
    @(posedge clk);
    cyc++;
    model(v, d, rdy, ls, rs);
    #1;
    h = '{0, 0};
    if (mq.size() > 0) h = mq[0];
    check("pix_valid", bus.pix_valid, mq.size() > 0);
    check("pix_data", bus.pix_data, h.v);
    check("pix_last", bus.pix_last, h.last);
    check("busy", busy, ms != 0);
    check("debug_state", debug_state, ms);
    check("overflow", overflow, ovf);
  endtask
  task automatic run_line(input int n, input int d, input bit rdy, input bit gap);
    got.delete();
    got_last = 0;
    step(0, 0, rdy, 1, 0);
    for (int i = 0; i < n; i++) begin
      step(1, d, rdy, 0, 0);
      if (gap) step(0, 0, rdy, 0, 0);
    end
    repeat (4) step(0, 0, rdy, 0, 0);
  endtask
  initial begin
    bus.bf_valid = 0;
    bus.bf_data = '0;
    bus.pix_ready = 1;
    repeat (2) step(0, 0, 1, 0, 1);
    check("rst_busy", busy, 0);
    check("rst_pix_data", bus.pix_data, 0);
    run_line(40, 800, 1, 0);
    check("t1_p0", got[0], 25);
    check("t1_p1", got[1], 50);
    check("t1_p9", got[9], 50);
    check("t1_cnt", got.size(), 10);
    step(0, 0, 1, 0, 1);
    run_line(40, -800, 1, 0);
    check("t2_neg_p0", got[0], 25);
    check("t2_neg_p1", got[1], 50);
    step(0, 0, 1, 0, 1);
    run_line(20, 'h20000, 1, 0);
    check("t2_sat_p0", got[0], 255);
    check("t2_sat_p4", got[4], 255);
    step(0, 0, 1, 0, 1);
    run_line(24, 800, 0, 0);
    check("t3_overflow", overflow, 1);
    check("t3_head", bus.pix_data, 25);
    got.delete();
    repeat (10) step(0, 0, 1, 0, 0);
    check("t3_drained", got.size(), 4);
    check("t3_valid_low", bus.pix_valid, 0);
    step(0, 0, 1, 0, 1);
    got.delete();
    got_last = 0;
    step(0, 0, 1, 1, 0);
    for (int i = 0; i < DEC * LINE_LEN; i++) step(1, 800, i < DEC * LINE_LEN - 8, 0, 0);
    repeat (6) step(1, 800, 0, 0, 0);
    check("t4_drain_busy", busy, 1);
    repeat (8) step(1, 800, 1, 0, 0);
    check("t4_pixels", got.size(), LINE_LEN);
    check("t4_last_cnt", got_last, 1);
    check("t4_last_val", got[LINE_LEN-1], 50);
    check("t4_idle", busy, 0);
    check("t4_no_ovf", overflow, 0);
    got.delete();
    step(0, 0, 1, 1, 0);
    for (int i = 0; i < 500; i++) step(1, 800, 1, i == 100, 0);
    step(1, 800, 1, 0, 1);
    check("t5_state", debug_state, 0);
    check("t5_valid", bus.pix_valid, 0);
    check("t5_busy", busy, 0);
    run_line(40, 800, 1, 0);
    check("t5_fresh_p0", got[0], 25);
    step(0, 0, 1, 0, 1);
    run_line(40, 800, 1, 1);
    check("t6_p0", got[0], 25);
    check("t6_p9", got[9], 50);
    step(0, 0, 1, 0, 1);
    for (int l = 0; l < 3; l++) begin
      step(0, 0, 1, 1, 0);
      for (int c = 0; c < 8000; c++) begin
        step($urandom_range(0, 9) < 7,
             ($urandom_range(0, 15) == 0) ? 'h20000 : int'($urandom),
             (l == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6),
             $urandom_range(0, 99) == 0,
             $urandom_range(0, 2999) == 0);
        if (!busy) break;
      end
      check("rand_line_done", busy, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
